brainhack_io: RTL

Parametrised Brainfuck execution core with byte I/O, halt and error reporting. It fetches 4-bit opcodes from external program memory and operates on external tape and loop-stack memories, all with asynchronous read and clocked write. It executes one instruction per cycle, except I/O instructions, which wait on valid/ready handshakes. It sits between the program/tape/stack RAMs and a host byte stream (UART bridge or test harness).

---
 rtl/brainhack_io_pkg.sv | 33 +++
 rtl/brainhack_io_decode.sv | 16 +
 rtl/brainhack_io.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/brainhack_io_pkg.sv
// brainhack_io_pkg: opcodes, FSM states, error codes and decode classes
// shared by the Brainfuck execution core.
package brainhack_io_pkg;

    localparam logic [3:0] OP_OUT   = 4'h0;
    localparam logic [3:0] OP_IN    = 4'h1;
    localparam logic [3:0] OP_INC   = 4'h2;
    localparam logic [3:0] OP_DEC   = 4'h3;
    localparam logic [3:0] OP_RIGHT = 4'h4;
    localparam logic [3:0] OP_LEFT  = 4'h5;
    localparam logic [3:0] OP_OPEN  = 4'h6;
    localparam logic [3:0] OP_CLOSE = 4'h7;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
    localparam logic [1:0] ERR_UNMATCHED = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_SKIP, S_OUT, S_IN, S_HALT, S_ERROR
    } state_t;

    // dec selects the second opcode of each pair: ',' '-' '<' ']'
    typedef struct packed {
        logic tape;
        logic ptr;
        logic loop;
        logic io;
        logic halt;
        logic dec;
    } op_class_t;

endpackage

// File: rtl/brainhack_io_decode.sv
// brainhack_io_decode: combinational opcode to instruction-class flags.
module brainhack_io_decode
    import brainhack_io_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  cls
);

    assign cls.halt = opcode[3];
    assign cls.io   = !opcode[3] && opcode[2:1] == 2'd0;
    assign cls.tape = !opcode[3] && opcode[2:1] == 2'd1;
    assign cls.ptr  = !opcode[3] && opcode[2:1] == 2'd2;
    assign cls.loop = !opcode[3] && opcode[2:1] == 2'd3;
    assign cls.dec  = opcode[0];

endmodule

// File: rtl/brainhack_io.sv
// brainhack_io: Brainfuck core with byte I/O handshakes, halt and error reporting.
// Define BRAINHACK_RETIRE_COUNT_EN to add the o_retired instruction counter.
module brainhack_io
    import brainhack_io_pkg::*;
#(
    parameter int TAPE_DATA_WIDTH  = 8,
    parameter int TAPE_ADDR_WIDTH  = 8,
    parameter int PRG_ADDR_WIDTH   = 8,
    parameter int STACK_ADDR_WIDTH = 4
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic                        i_start,
    input  logic [3:0]                  i_prgmem_data,
    output logic [PRG_ADDR_WIDTH-1:0]   o_prgmem_addr,
    input  logic [TAPE_DATA_WIDTH-1:0]  i_tape_data,
    output logic [TAPE_ADDR_WIDTH-1:0]  o_tape_addr,
    output logic [TAPE_DATA_WIDTH-1:0]  o_tape_data,
    output logic                        o_tape_in,
    input  logic [PRG_ADDR_WIDTH-1:0]   i_stack_data,
    output logic [STACK_ADDR_WIDTH-1:0] o_stack_addr,
    output logic [PRG_ADDR_WIDTH-1:0]   o_stack_data,
    output logic                        o_stack_in,
    output logic [TAPE_DATA_WIDTH-1:0]  o_out_data,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    input  logic [TAPE_DATA_WIDTH-1:0]  i_in_data,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
`ifdef BRAINHACK_RETIRE_COUNT_EN
    output logic [31:0]                 o_retired,
`endif
    output logic                        o_busy,
    output logic                        o_halted,
    output logic [1:0]                  o_error
);

    localparam int DW = STACK_ADDR_WIDTH + 1;
    localparam logic [STACK_ADDR_WIDTH-1:0] SP_MAX    = '1;
    localparam logic [DW-1:0]               DEPTH_MAX = '1;
    localparam logic [DW-1:0]               DEPTH_ONE = DW'(1);

    state_t                      state, state_nx;
    logic [PRG_ADDR_WIDTH-1:0]   pc, pc_nx, pc_inc;
    logic [TAPE_ADDR_WIDTH-1:0]  ptr, ptr_nx;
    logic [STACK_ADDR_WIDTH-1:0] sp, sp_nx;
    logic [DW-1:0]               depth, depth_nx;
    logic [1:0]                  err, err_nx;
    logic [TAPE_DATA_WIDTH-1:0]  out_data, out_data_nx;
    logic                        cell_zero, start_ok;
    op_class_t                   cls;

    brainhack_io_decode u_decode (
        .opcode (i_prgmem_data),
        .cls    (cls)
    );

    assign pc_inc    = pc + 1'b1;
    assign cell_zero = i_tape_data == '0;
    assign start_ok  = i_start && (state == S_IDLE || state == S_HALT || state == S_ERROR);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            ptr      <= '0;
            sp       <= '0;
            depth    <= '0;
            err      <= ERR_NONE;
            out_data <= '0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            ptr      <= ptr_nx;
            sp       <= sp_nx;
            depth    <= depth_nx;
            err      <= err_nx;
            out_data <= out_data_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        ptr_nx       = ptr;
        sp_nx        = sp;
        depth_nx     = depth;
        err_nx       = err;
        out_data_nx  = out_data;
        o_tape_in    = 1'b0;
        o_tape_data  = i_tape_data;
        o_stack_in   = 1'b0;
        o_stack_addr = sp;
        o_stack_data = pc_inc;
        case (state)
            S_IDLE, S_HALT, S_ERROR: if (start_ok) begin
                state_nx = S_RUN;
                pc_nx    = '0;
                ptr_nx   = '0;
                sp_nx    = '0;
                depth_nx = '0;
                err_nx   = ERR_NONE;
            end
            S_RUN: begin
                if (cls.halt) begin
                    state_nx = S_HALT;
                end else if (cls.io) begin
                    state_nx    = cls.dec ? S_IN : S_OUT;
                    out_data_nx = cls.dec ? out_data : i_tape_data;
                end else if (cls.tape) begin
                    o_tape_in   = 1'b1;
                    o_tape_data = cls.dec ? i_tape_data - 1'b1 : i_tape_data + 1'b1;
                    pc_nx       = pc_inc;
                end else if (cls.ptr) begin
                    ptr_nx = cls.dec ? ptr - 1'b1 : ptr + 1'b1;
                    pc_nx  = pc_inc;
                end else if (!cls.dec) begin
                    if (cell_zero) begin
                        depth_nx = DEPTH_ONE;
                        pc_nx    = pc_inc;
                        state_nx = S_SKIP;
                    end else if (sp == SP_MAX) begin
                        state_nx = S_ERROR;
                        err_nx   = ERR_OVERFLOW;
                    end else begin
                        o_stack_in = 1'b1;
                        sp_nx      = sp + 1'b1;
                        pc_nx      = pc_inc;
                    end
                end else if (sp == '0) begin
                    state_nx = S_ERROR;
                    err_nx   = ERR_UNDERFLOW;
                end else begin
                    // ']' peeks the loop head; the entry is popped only on exit
                    o_stack_addr = sp - 1'b1;
                    pc_nx        = cell_zero ? pc_inc : i_stack_data;
                    sp_nx        = cell_zero ? sp - 1'b1 : sp;
                end
            end
            S_SKIP: begin
                if (cls.halt || (cls.loop && !cls.dec && depth == DEPTH_MAX)) begin
                    state_nx = S_ERROR;
                    err_nx   = ERR_UNMATCHED;
                end else begin
                    pc_nx    = pc_inc;
                    depth_nx = !cls.loop ? depth : cls.dec ? depth - 1'b1 : depth + 1'b1;
                    state_nx = (cls.loop && cls.dec && depth == DEPTH_ONE) ? S_RUN : S_SKIP;
                end
            end
            S_OUT: if (i_out_ready) begin
                pc_nx    = pc_inc;
                state_nx = S_RUN;
            end
            S_IN: if (i_in_valid) begin
                o_tape_in   = 1'b1;
                o_tape_data = i_in_data;
                pc_nx       = pc_inc;
                state_nx    = S_RUN;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign o_prgmem_addr = pc;
    assign o_tape_addr   = ptr;
    assign o_out_data    = out_data;
    assign o_out_valid   = state == S_OUT;
    assign o_in_ready    = state == S_IN;
    assign o_busy        = state == S_RUN || state == S_SKIP || state == S_OUT || state == S_IN;
    assign o_halted      = state == S_HALT;
    assign o_error       = err;

`ifdef BRAINHACK_RETIRE_COUNT_EN
    logic retire;
    // An instruction retires when RUN continues (or enters SKIP), or an I/O handshake completes
    assign retire = (state == S_RUN && (state_nx == S_RUN || state_nx == S_SKIP)) ||
                    ((state == S_OUT || state == S_IN) && state_nx == S_RUN);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            o_retired <= '0;
        else if (start_ok)
            o_retired <= '0;
        else if (retire && o_retired != '1)
            o_retired <= o_retired + 1'b1;
    end
`endif

endmodule
